stopwatch_bcd: RTL

Minutes:seconds stopwatch that sits directly downstream of the frequency divider. It consumes a one-cycle enable pulse derived from the 50 MHz system clock and counts elapsed time in BCD from 00:00 to 59:59. It supports start/stop, lap-freeze and clear controls. Its digit outputs feed the seven-segment decoder stage. The block runs entirely on the system clock; the divider output is used only as an enable, never as a clock.

---
 rtl/stopwatch_bcd_if.sv | 25 ++
 rtl/stopwatch_bcd.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_if.sv
// Control and display bundle of the BCD stopwatch.
// Controller side (master) drives tick/start_stop/lap/clear and observes the
// BCD digits plus running/wrap; the stopwatch (slave) does the opposite.
interface stopwatch_bcd_if;
    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    modport master (
        output tick, start_stop, lap, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// Minutes:seconds BCD stopwatch (00:00..59:59) clocked by the system clock,
// advanced by a divider enable pulse prescaled by TICKS_PER_SEC.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   sw   - stopwatch_bcd_if.slave: tick, start_stop, lap, clear in;
//          sec_ones, sec_tens, min_ones, min_tens, running, wrap out
// All outputs are registered.
module stopwatch_bcd #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_bcd_if.slave  sw
);
    localparam int unsigned PRE_W = 16;
    localparam int unsigned DIG_W = 4;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_e;

    // digit index: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens
    typedef logic [3:0][DIG_W-1:0] time_t;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    time_t            live_q, live_d;
    time_t            snap_q, snap_d;
    time_t            disp_q, disp_d;
    logic             ss_prev_q, lap_prev_q;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;

    logic             ss_edge, lap_edge, counting, sec_adv;

    assign ss_edge  = sw.start_stop & ~ss_prev_q;
    assign lap_edge = sw.lap & ~lap_prev_q;
    // counting follows the state held at the start of the cycle
    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            live_q     <= '0;
            snap_q     <= '0;
            disp_q     <= '0;
            ss_prev_q  <= 1'b1;
            lap_prev_q <= 1'b1;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            live_q     <= live_d;
            snap_q     <= snap_d;
            disp_q     <= disp_d;
            ss_prev_q  <= sw.start_stop;
            lap_prev_q <= sw.lap;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    // Next-state, prescaler, BCD carry chain and output selection
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        live_d  = live_q;
        snap_d  = snap_q;
        wrap_d  = 1'b0;
        sec_adv = 1'b0;

        if (counting && sw.tick) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                sec_adv = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        if (sec_adv) begin
            if (live_q[0] == DIG_W'(9)) begin
                live_d[0] = '0;
                if (live_q[1] == DIG_W'(5)) begin
                    live_d[1] = '0;
                    if (live_q[2] == DIG_W'(9)) begin
                        live_d[2] = '0;
                        if (live_q[3] == DIG_W'(5)) begin
                            live_d[3] = '0;
                            wrap_d    = 1'b1;
                        end else begin
                            live_d[3] = live_q[3] + DIG_W'(1);
                        end
                    end else begin
                        live_d[2] = live_q[2] + DIG_W'(1);
                    end
                end else begin
                    live_d[1] = live_q[1] + DIG_W'(1);
                end
            end else begin
                live_d[0] = live_q[0] + DIG_W'(1);
            end
        end

        // start_stop has priority; a simultaneous lap edge is dropped
        if (ss_edge) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_LAP:   state_d = ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (lap_edge) begin
            if (state_q == ST_RUN) begin
                state_d = ST_LAP;
                snap_d  = live_q;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUN;
            end
        end

        if (sw.clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            live_d  = '0;
            snap_d  = '0;
            wrap_d  = 1'b0;
        end

        disp_d    = (state_d == ST_LAP) ? snap_d : live_d;
        running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    end

    assign sw.sec_ones = disp_q[0];
    assign sw.sec_tens = disp_q[1];
    assign sw.min_ones = disp_q[2];
    assign sw.min_tens = disp_q[3];
    assign sw.running  = running_q;
    assign sw.wrap     = wrap_q;

endmodule
